// File: rtl/operand_gen_pkg.sv
// ============================================================================
//  operand_gen_pkg : opcode/funct/REGIMM codes and operand-select encodings
//  Revision : 1.0
// ============================================================================
`default_nettype none

package operand_gen_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LWL      = 6'h22;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_LWR      = 6'h26;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SWL      = 6'h2A;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_SWR      = 6'h2E;

  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [4:0] RT_BLTZAL   = 5'h10;
  localparam logic [4:0] RT_BGEZAL   = 5'h11;

  localparam int LINK_OFFSET = 8;

  typedef enum logic [1:0] {
    IMM_ZERO    = 2'd0,
    IMM_ZEXT    = 2'd1,
    IMM_ZEXT_HI = 2'd2,
    IMM_SEXT    = 2'd3
  } imm_kind_e;

  typedef enum logic [1:0] {
    SRC1_ZERO = 2'd0,
    SRC1_REG  = 2'd1,
    SRC1_LINK = 2'd2
  } src1_e;

  function automatic logic is_mem(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_mem = 1'b1;
      default:                             is_mem = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_gen_if.sv
// ============================================================================
//  operand_gen_if : upstream bundle, result broadcast and dispatch bundle bus
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface operand_gen_if #(
  parameter int WAYS      = 2,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int CDB_PORTS = 2
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [WAYS-1:0]           in_way_valid;
  logic [WAYS*DATA_W-1:0]    in_pc;
  logic [WAYS*6-1:0]         in_op;
  logic [WAYS*6-1:0]         in_funct;
  logic [WAYS*5-1:0]         in_rt;
  logic [WAYS*16-1:0]        in_imm;
  logic [WAYS-1:0]           in_rd_is_rsid_1;
  logic [WAYS-1:0]           in_rd_is_rsid_2;
  logic [WAYS*DATA_W-1:0]    in_rd_data_1;
  logic [WAYS*DATA_W-1:0]    in_rd_data_2;
  logic [CDB_PORTS-1:0]      cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag;
  logic [CDB_PORTS*DATA_W-1:0] cdb_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WAYS-1:0]           out_way_valid;
  logic [WAYS-1:0]           out_is_rsid_1;
  logic [WAYS-1:0]           out_is_rsid_2;
  logic [WAYS*DATA_W-1:0]    out_data_1;
  logic [WAYS*DATA_W-1:0]    out_data_2;

  modport master (
    output flush, in_valid, in_way_valid, in_pc, in_op, in_funct, in_rt, in_imm,
           in_rd_is_rsid_1, in_rd_is_rsid_2, in_rd_data_1, in_rd_data_2,
           cdb_valid, cdb_tag, cdb_data, out_ready,
    input  in_ready, out_valid, out_way_valid, out_is_rsid_1, out_is_rsid_2,
           out_data_1, out_data_2
  );

  modport slave (
    input  flush, in_valid, in_way_valid, in_pc, in_op, in_funct, in_rt, in_imm,
           in_rd_is_rsid_1, in_rd_is_rsid_2, in_rd_data_1, in_rd_data_2,
           cdb_valid, cdb_tag, cdb_data, out_ready,
    output in_ready, out_valid, out_way_valid, out_is_rsid_1, out_is_rsid_2,
           out_data_1, out_data_2
  );
endinterface

`default_nettype wire

// File: rtl/operand_gen_sel.sv
// ============================================================================
//  operand_sel : combinational per-way source operand mux (reg / imm / link)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module operand_sel
  import operand_gen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              valid,
  input  logic [DATA_W-1:0] pc,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [4:0]        rt,
  input  logic [15:0]       imm,
  input  logic              rd_is_rsid_1,
  input  logic              rd_is_rsid_2,
  input  logic [DATA_W-1:0] rd_data_1,
  input  logic [DATA_W-1:0] rd_data_2,
  output logic              is_rsid_1,
  output logic              is_rsid_2,
  output logic [DATA_W-1:0] data_1,
  output logic [DATA_W-1:0] data_2
);

  src1_e             w_src1;
  imm_kind_e         w_kind;
  logic              w_op2_reg;
  logic [DATA_W-1:0] w_imm_val;

  always_comb begin
    w_src1    = SRC1_ZERO;
    w_kind    = IMM_ZERO;
    w_op2_reg = 1'b0;
    case (op)
      OP_SPECIAL: begin
        w_src1    = (funct == FUNCT_JALR) ? SRC1_LINK : SRC1_REG;
        w_op2_reg = 1'b1;
      end
      OP_SPECIAL2: begin
        w_src1    = SRC1_REG;
        w_op2_reg = 1'b1;
      end
      OP_JAL:    w_src1 = SRC1_LINK;
      OP_REGIMM: w_src1 = (rt == RT_BLTZAL || rt == RT_BGEZAL) ? SRC1_LINK : SRC1_ZERO;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_src1 = SRC1_REG;
        w_kind = IMM_SEXT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_src1 = SRC1_REG;
        w_kind = IMM_ZEXT;
      end
      OP_LUI: begin
        w_src1 = SRC1_REG;
        w_kind = IMM_ZEXT_HI;
      end
      default: begin
        if (is_mem(op)) begin
          w_src1 = SRC1_REG;
          w_kind = IMM_SEXT;
        end
      end
    endcase
  end

  always_comb begin
    case (w_kind)
      IMM_ZEXT:    w_imm_val = DATA_W'(imm);
      IMM_ZEXT_HI: w_imm_val = DATA_W'({imm, 16'h0000});
      IMM_SEXT:    w_imm_val = {{(DATA_W-16){imm[15]}}, imm};
      default:     w_imm_val = '0;
    endcase
  end

  always_comb begin
    data_1    = '0;
    is_rsid_1 = 1'b0;
    data_2    = w_imm_val;
    is_rsid_2 = 1'b0;
    case (w_src1)
      SRC1_REG: begin
        data_1    = rd_data_1;
        is_rsid_1 = rd_is_rsid_1;
      end
      SRC1_LINK: data_1 = pc + DATA_W'(LINK_OFFSET);
      default:   data_1 = '0;
    endcase
    if (w_op2_reg) begin
      data_2    = rd_data_2;
      is_rsid_2 = rd_is_rsid_2;
    end
    // Masked ways carry nothing, so they can never be woken later.
    if (!valid) begin
      data_1    = '0;
      is_rsid_1 = 1'b0;
      data_2    = '0;
      is_rsid_2 = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_gen.sv
// ============================================================================
//  operand_gen : WAYS-wide operand select, output+skid buffer, CDB wakeup
//  Option macro: OPGEN_WAKEUP_EN builds the tag snoop and capture bypass.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module operand_gen
  import operand_gen_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  operand_gen_if.slave  bus
);

  localparam int VW = WAYS * DATA_W;

  logic [WAYS-1:0] w_sel_r1, w_sel_r2, w_in_r1, w_in_r2;
  logic [WAYS-1:0] w_out_r1, w_out_r2, w_skid_r1, w_skid_r2;
  logic [VW-1:0]   w_sel_d1, w_sel_d2, w_in_d1, w_in_d2;
  logic [VW-1:0]   w_out_d1, w_out_d2, w_skid_d1, w_skid_d2;

  logic            r_in_ready;
  logic            r_out_valid, r_skid_valid;
  logic [WAYS-1:0] r_out_wv, r_out_r1, r_out_r2;
  logic [WAYS-1:0] r_skid_wv, r_skid_r1, r_skid_r2;
  logic [VW-1:0]   r_out_d1, r_out_d2, r_skid_d1, r_skid_d2;

  logic w_accept, w_out_free, w_skid_next;

`ifdef OPGEN_WAKEUP_EN
  // Descending scan so the lowest-numbered matching port is the last writer.
  function automatic logic [DATA_W:0] wake(
    input logic                          rsid,
    input logic [DATA_W-1:0]             data,
    input logic [CDB_PORTS-1:0]          cv,
    input logic [CDB_PORTS*TAG_W-1:0]    ct,
    input logic [CDB_PORTS*DATA_W-1:0]   cd
  );
    logic [DATA_W:0] res;
    res = {rsid, data};
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (rsid && cv[p] && (data[TAG_W-1:0] == ct[p*TAG_W +: TAG_W]))
        res = {1'b0, cd[p*DATA_W +: DATA_W]};
    end
    return res;
  endfunction
`else
  logic unused_cdb;
  assign unused_cdb = ^{bus.cdb_valid, bus.cdb_tag, bus.cdb_data};
`endif

  genvar w;
  generate
    for (w = 0; w < WAYS; w++) begin : g_way
      operand_sel #(.DATA_W(DATA_W)) u_sel (
        .valid        (bus.in_way_valid[w]),
        .pc           (bus.in_pc[w*DATA_W +: DATA_W]),
        .op           (bus.in_op[w*6 +: 6]),
        .funct        (bus.in_funct[w*6 +: 6]),
        .rt           (bus.in_rt[w*5 +: 5]),
        .imm          (bus.in_imm[w*16 +: 16]),
        .rd_is_rsid_1 (bus.in_rd_is_rsid_1[w]),
        .rd_is_rsid_2 (bus.in_rd_is_rsid_2[w]),
        .rd_data_1    (bus.in_rd_data_1[w*DATA_W +: DATA_W]),
        .rd_data_2    (bus.in_rd_data_2[w*DATA_W +: DATA_W]),
        .is_rsid_1    (w_sel_r1[w]),
        .is_rsid_2    (w_sel_r2[w]),
        .data_1       (w_sel_d1[w*DATA_W +: DATA_W]),
        .data_2       (w_sel_d2[w*DATA_W +: DATA_W])
      );
`ifdef OPGEN_WAKEUP_EN
      assign {w_in_r1[w], w_in_d1[w*DATA_W +: DATA_W]} =
        wake(w_sel_r1[w], w_sel_d1[w*DATA_W +: DATA_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      assign {w_in_r2[w], w_in_d2[w*DATA_W +: DATA_W]} =
        wake(w_sel_r2[w], w_sel_d2[w*DATA_W +: DATA_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      assign {w_out_r1[w], w_out_d1[w*DATA_W +: DATA_W]} =
        wake(r_out_r1[w], r_out_d1[w*DATA_W +: DATA_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      assign {w_out_r2[w], w_out_d2[w*DATA_W +: DATA_W]} =
        wake(r_out_r2[w], r_out_d2[w*DATA_W +: DATA_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      assign {w_skid_r1[w], w_skid_d1[w*DATA_W +: DATA_W]} =
        wake(r_skid_r1[w], r_skid_d1[w*DATA_W +: DATA_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      assign {w_skid_r2[w], w_skid_d2[w*DATA_W +: DATA_W]} =
        wake(r_skid_r2[w], r_skid_d2[w*DATA_W +: DATA_W], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`else
      assign {w_in_r1[w], w_in_d1[w*DATA_W +: DATA_W]}     = {w_sel_r1[w], w_sel_d1[w*DATA_W +: DATA_W]};
      assign {w_in_r2[w], w_in_d2[w*DATA_W +: DATA_W]}     = {w_sel_r2[w], w_sel_d2[w*DATA_W +: DATA_W]};
      assign {w_out_r1[w], w_out_d1[w*DATA_W +: DATA_W]}   = {r_out_r1[w], r_out_d1[w*DATA_W +: DATA_W]};
      assign {w_out_r2[w], w_out_d2[w*DATA_W +: DATA_W]}   = {r_out_r2[w], r_out_d2[w*DATA_W +: DATA_W]};
      assign {w_skid_r1[w], w_skid_d1[w*DATA_W +: DATA_W]} = {r_skid_r1[w], r_skid_d1[w*DATA_W +: DATA_W]};
      assign {w_skid_r2[w], w_skid_d2[w*DATA_W +: DATA_W]} = {r_skid_r2[w], r_skid_d2[w*DATA_W +: DATA_W]};
`endif
    end
  endgenerate

  always_comb begin
    w_accept    = bus.in_valid && r_in_ready;
    w_out_free  = !r_out_valid || bus.out_ready;
    w_skid_next = r_skid_valid ? !w_out_free : (w_accept && !w_out_free);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_wv     <= '0;
      r_out_r1     <= '0;
      r_out_r2     <= '0;
      r_out_d1     <= '0;
      r_out_d2     <= '0;
      r_skid_wv    <= '0;
      r_skid_r1    <= '0;
      r_skid_r2    <= '0;
      r_skid_d1    <= '0;
      r_skid_d2    <= '0;
    end else begin
      r_in_ready   <= !w_skid_next;
      r_skid_valid <= w_skid_next;
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_wv    <= r_skid_wv;
          r_out_r1    <= w_skid_r1;
          r_out_r2    <= w_skid_r2;
          r_out_d1    <= w_skid_d1;
          r_out_d2    <= w_skid_d2;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_wv    <= bus.in_way_valid;
          r_out_r1    <= w_in_r1;
          r_out_r2    <= w_in_r2;
          r_out_d1    <= w_in_d1;
          r_out_d2    <= w_in_d2;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else begin
        // Stalled: hold the bundle, only wakeups may change it.
        r_out_r1 <= w_out_r1;
        r_out_r2 <= w_out_r2;
        r_out_d1 <= w_out_d1;
        r_out_d2 <= w_out_d2;
      end
      if (r_skid_valid && !w_out_free) begin
        r_skid_r1 <= w_skid_r1;
        r_skid_r2 <= w_skid_r2;
        r_skid_d1 <= w_skid_d1;
        r_skid_d2 <= w_skid_d2;
      end else if (!r_skid_valid && w_accept && !w_out_free) begin
        r_skid_wv <= bus.in_way_valid;
        r_skid_r1 <= w_in_r1;
        r_skid_r2 <= w_in_r2;
        r_skid_d1 <= w_in_d1;
        r_skid_d2 <= w_in_d2;
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_way_valid = r_out_wv;
  assign bus.out_is_rsid_1 = r_out_r1;
  assign bus.out_is_rsid_2 = r_out_r2;
  assign bus.out_data_1    = r_out_d1;
  assign bus.out_data_2    = r_out_d2;

endmodule

`default_nettype wire

// File: tb/tb_operand_gen.sv
// ============================================================================
//  tb_operand_gen : directed vector table plus handshake/wakeup/flush sequences
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_operand_gen;
  import operand_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_gen_if #(.WAYS(2), .DATA_W(32), .TAG_W(4), .CDB_PORTS(2)) bus ();

  operand_gen #(.WAYS(2), .DATA_W(32), .TAG_W(4), .CDB_PORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]       wv;
    logic [1:0][31:0] pc;
    logic [1:0][5:0]  op;
    logic [1:0][5:0]  funct;
    logic [1:0][4:0]  rt;
    logic [1:0][15:0] imm;
    logic [1:0]       rs1, rs2;
    logic [1:0][31:0] d1, d2;
    logic [1:0][31:0] e1, e2;
    logic [1:0]       er1, er2;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input int w, input logic [5:0] op, input logic [5:0] funct,
                      input logic [4:0] rt, input logic [15:0] imm, input logic [31:0] pc,
                      input logic rs1, input logic [31:0] d1, input logic rs2, input logic [31:0] d2,
                      input logic [31:0] e1, input logic er1, input logic [31:0] e2, input logic er2);
    vt[i].op[w] = op;   vt[i].funct[w] = funct; vt[i].rt[w] = rt; vt[i].imm[w] = imm;
    vt[i].pc[w] = pc;   vt[i].rs1[w] = rs1;     vt[i].d1[w] = d1; vt[i].rs2[w] = rs2;
    vt[i].d2[w] = d2;   vt[i].e1[w] = e1;       vt[i].er1[w] = er1;
    vt[i].e2[w] = e2;   vt[i].er2[w] = er2;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.in_way_valid    = v.wv;
    bus.in_pc           = v.pc;
    bus.in_op           = v.op;
    bus.in_funct        = v.funct;
    bus.in_rt           = v.rt;
    bus.in_imm          = v.imm;
    bus.in_rd_is_rsid_1 = v.rs1;
    bus.in_rd_is_rsid_2 = v.rs2;
    bus.in_rd_data_1    = v.d1;
    bus.in_rd_data_2    = v.d2;
  endtask

  // Way-0-only bundle whose identity shows up as way0 operand 2.
  task automatic drive_ori(input logic [15:0] k);
    bus.in_way_valid = 2'b01;
    bus.in_pc = '0; bus.in_funct = '0; bus.in_rt = '0;
    bus.in_op = {6'h00, OP_ORI};
    bus.in_imm = {16'h0000, k};
    bus.in_rd_is_rsid_1 = 2'b00; bus.in_rd_is_rsid_2 = 2'b00;
    bus.in_rd_data_1 = '0; bus.in_rd_data_2 = '0;
  endtask

  task automatic drive_spec(input logic [1:0] wv, input logic [1:0] rs1, input logic [63:0] d1,
                            input logic [1:0] rs2, input logic [63:0] d2);
    bus.in_way_valid = wv;
    bus.in_pc = '0; bus.in_rt = '0; bus.in_imm = '0;
    bus.in_op = {OP_SPECIAL, OP_SPECIAL};
    bus.in_funct = {6'h21, 6'h21};
    bus.in_rd_is_rsid_1 = rs1; bus.in_rd_is_rsid_2 = rs2;
    bus.in_rd_data_1 = d1;     bus.in_rd_data_2 = d2;
  endtask

  task automatic idle_inputs;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0;
    drive_ori(16'h0);
    bus.in_way_valid = 2'b00;
  endtask

  initial begin
    logic [31:0] exp_w0;
    logic        exp_r0;

    // vector table: op funct rt imm pc | rs1 d1 rs2 d2 | e1 er1 e2 er2
    vt[0].wv = 2'b11;
    setw(0, 0, OP_ORI,  6'h00, 5'h00, 16'h8001, 32'h0, 1'b0, 32'h10, 1'b1, 32'hDEAD,
         32'h10, 1'b0, 32'h00008001, 1'b0);
    setw(0, 1, OP_ADDI, 6'h00, 5'h00, 16'hFFFF, 32'h0, 1'b0, 32'h20, 1'b0, 32'hBEEF,
         32'h20, 1'b0, 32'hFFFFFFFF, 1'b0);
    vt[1].wv = 2'b11;
    setw(1, 0, OP_JAL,    6'h00, 5'h00, 16'h1234, 32'hFFFFFFFC, 1'b1, 32'h55, 1'b1, 32'hDEAD,
         32'h00000004, 1'b0, 32'h0, 1'b0);
    setw(1, 1, OP_REGIMM, 6'h00, RT_BLTZAL, 16'h0004, 32'h100, 1'b0, 32'h66, 1'b0, 32'h77,
         32'h108, 1'b0, 32'h0, 1'b0);
    vt[2].wv = 2'b11;
    setw(2, 0, OP_SPECIAL, 6'h21, 5'h00, 16'h0, 32'h0, 1'b1, 32'h3, 1'b0, 32'h77,
         32'h3, 1'b1, 32'h77, 1'b0);
    setw(2, 1, OP_SPECIAL, FUNCT_JALR, 5'h00, 16'h0, 32'h200, 1'b1, 32'h9, 1'b1, 32'h99,
         32'h208, 1'b0, 32'h99, 1'b1);
    vt[3].wv = 2'b11;
    setw(3, 0, OP_LUI, 6'h00, 5'h00, 16'h1234, 32'h0, 1'b0, 32'h5, 1'b0, 32'h1,
         32'h5, 1'b0, 32'h12340000, 1'b0);
    setw(3, 1, OP_LW,  6'h00, 5'h00, 16'h8000, 32'h0, 1'b0, 32'h1000, 1'b0, 32'h2,
         32'h1000, 1'b0, 32'hFFFF8000, 1'b0);
    vt[4].wv = 2'b11;
    setw(4, 0, OP_BEQ,    6'h00, 5'h00, 16'h0010, 32'h40, 1'b0, 32'h7, 1'b0, 32'h8,
         32'h0, 1'b0, 32'h0, 1'b0);
    setw(4, 1, OP_REGIMM, 6'h00, 5'h01, 16'h0010, 32'h300, 1'b0, 32'h7, 1'b0, 32'h8,
         32'h0, 1'b0, 32'h0, 1'b0);
    vt[5].wv = 2'b01;
    setw(5, 0, OP_ANDI, 6'h00, 5'h00, 16'hFFFF, 32'h0, 1'b1, 32'hA, 1'b0, 32'h1,
         32'hA, 1'b1, 32'h0000FFFF, 1'b0);
    setw(5, 1, OP_ORI,  6'h00, 5'h00, 16'h1111, 32'h0, 1'b1, 32'h33, 1'b1, 32'h44,
         32'h0, 1'b0, 32'h0, 1'b0);
    vt[6].wv = 2'b11;
    setw(6, 0, OP_SPECIAL2, 6'h02, 5'h00, 16'h0, 32'h0, 1'b0, 32'h11, 1'b1, 32'h22,
         32'h11, 1'b0, 32'h22, 1'b1);
    setw(6, 1, OP_SW,       6'h00, 5'h00, 16'h0004, 32'h0, 1'b0, 32'h40, 1'b0, 32'h5,
         32'h40, 1'b0, 32'h4, 1'b0);
    vt[7].wv = 2'b11;
    setw(7, 0, OP_J,     6'h00, 5'h00, 16'h0100, 32'h80, 1'b1, 32'h3, 1'b0, 32'h1,
         32'h0, 1'b0, 32'h0, 1'b0);
    setw(7, 1, OP_SLTIU, 6'h00, 5'h00, 16'h7FFF, 32'h0, 1'b0, 32'h1, 1'b0, 32'h2,
         32'h1, 1'b0, 32'h7FFF, 1'b0);

    // reset state
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b1;
    tick();
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_data", {bus.out_data_1, bus.out_data_2}, 128'd0);
    chk("rst_flags", 128'({bus.out_way_valid, bus.out_is_rsid_1, bus.out_is_rsid_2}), 128'd0);
    rst = 1'b0;
    tick();

    // back-to-back table vectors, one bundle per cycle
    for (int i = 0; i < 8; i++) begin
      drive_vec(vt[i]);
      bus.in_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), 128'(bus.out_valid), 128'd1);
      chk($sformatf("vec%0d_wv", i), 128'(bus.out_way_valid), 128'(vt[i].wv));
      chk($sformatf("vec%0d_op1", i), 128'(bus.out_data_1), 128'(vt[i].e1));
      chk($sformatf("vec%0d_op2", i), 128'(bus.out_data_2), 128'(vt[i].e2));
      chk($sformatf("vec%0d_rsid", i), 128'({bus.out_is_rsid_1, bus.out_is_rsid_2}),
          128'({vt[i].er1, vt[i].er2}));
    end
    idle_inputs();
    tick();
    chk("drain_empty", 128'(bus.out_valid), 128'd0);

    // backpressure: hold, skid, then in-order release
    bus.out_ready = 1'b0;
    drive_ori(16'h0101); bus.in_valid = 1'b1;
    tick();
    chk("bp1_valid", 128'(bus.out_valid), 128'd1);
    chk("bp1_ready", 128'(bus.in_ready), 128'd1);
    chk("bp1_op2", 128'(bus.out_data_2[31:0]), 128'h101);
    drive_ori(16'h0202);
    tick();
    chk("bp2_ready", 128'(bus.in_ready), 128'd0);
    chk("bp2_hold", 128'(bus.out_data_2[31:0]), 128'h101);
    drive_ori(16'h0303);
    tick();
    chk("bp3_ready", 128'(bus.in_ready), 128'd0);
    chk("bp3_hold", 128'(bus.out_data_2[31:0]), 128'h101);
    bus.out_ready = 1'b1;
    tick();
    chk("rel1_op2", 128'(bus.out_data_2[31:0]), 128'h202);
    chk("rel1_ready", 128'(bus.in_ready), 128'd1);
    tick();
    chk("rel2_valid", 128'(bus.out_valid), 128'd1);
    chk("rel2_op2", 128'(bus.out_data_2[31:0]), 128'h303);
    idle_inputs();
    tick();
    chk("rel3_empty", 128'(bus.out_valid), 128'd0);

    // wakeup of a stalled output operand, port 0 wins a double match
`ifdef OPGEN_WAKEUP_EN
    exp_w0 = 32'hA; exp_r0 = 1'b0;
`else
    exp_w0 = 32'h5; exp_r0 = 1'b1;
`endif
    bus.out_ready = 1'b0;
    drive_spec(2'b01, 2'b01, 64'h5, 2'b00, 64'h1);
    bus.in_valid = 1'b1;
    tick();
    chk("wk_pend_r1", 128'(bus.out_is_rsid_1[0]), 128'd1);
    chk("wk_pend_d1", 128'(bus.out_data_1[31:0]), 128'h5);
    idle_inputs();
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {4'd5, 4'd5};
    bus.cdb_data  = {32'hB, 32'hA};
    tick();
    idle_inputs();
    chk("wk_d1", 128'(bus.out_data_1[31:0]), 128'(exp_w0));
    chk("wk_r1", 128'(bus.out_is_rsid_1[0]), 128'(exp_r0));
    tick();
    chk("wk_stable_d1", 128'(bus.out_data_1[31:0]), 128'(exp_w0));
    chk("wk_stable_d2", 128'(bus.out_data_2[31:0]), 128'h1);

    // wakeup while parked in skid, seen after release
    drive_spec(2'b01, 2'b01, 64'h5, 2'b00, 64'h2);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.cdb_valid = 2'b01; bus.cdb_tag = {4'd0, 4'd5}; bus.cdb_data = {32'h0, 32'h55};
    tick();
    idle_inputs();
    bus.out_ready = 1'b1;
    tick();
`ifdef OPGEN_WAKEUP_EN
    chk("skid_wk_d1", 128'({bus.out_is_rsid_1[0], bus.out_data_1[31:0]}), 128'({1'b0, 32'h55}));
`else
    chk("skid_wk_d1", 128'({bus.out_is_rsid_1[0], bus.out_data_1[31:0]}), 128'({1'b1, 32'h5}));
`endif
    chk("skid_wk_d2", 128'(bus.out_data_2[31:0]), 128'h2);
    tick();

    // capture-cycle bypass; tag compare looks only at the low bits
    drive_spec(2'b11, 2'b01, {32'h9, 32'h16}, 2'b10, {32'h7, 32'h0});
    bus.in_valid  = 1'b1;
    bus.cdb_valid = 2'b10;
    bus.cdb_tag   = {4'd6, 4'd7};
    bus.cdb_data  = {32'hC, 32'hD};
    tick();
    idle_inputs();
`ifdef OPGEN_WAKEUP_EN
    chk("byp_w0_op1", 128'({bus.out_is_rsid_1[0], bus.out_data_1[31:0]}), 128'({1'b0, 32'hC}));
`else
    chk("byp_w0_op1", 128'({bus.out_is_rsid_1[0], bus.out_data_1[31:0]}), 128'({1'b1, 32'h16}));
`endif
    chk("byp_w1_op2", 128'({bus.out_is_rsid_2[1], bus.out_data_2[63:32]}), 128'({1'b1, 32'h7}));
    tick();

    // flush with output and skid full, input offered
    bus.out_ready = 1'b0;
    drive_ori(16'h0A0A); bus.in_valid = 1'b1;
    tick();
    drive_ori(16'h0B0B);
    tick();
    drive_ori(16'h0C0C); bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl1_valid", 128'(bus.out_valid), 128'd0);
    chk("fl1_ready", 128'(bus.in_ready), 128'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("fl1_nothing", 128'(bus.out_valid), 128'd0);

    // flush while input would be accepted into skid
    bus.out_ready = 1'b0;
    drive_ori(16'h0D0D); bus.in_valid = 1'b1;
    tick();
    drive_ori(16'h0E0E); bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fl2_valid", 128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("fl2_nothing", 128'(bus.out_valid), 128'd0);

    // reset mid-stall
    bus.out_ready = 1'b0;
    drive_ori(16'h1111); bus.in_valid = 1'b1;
    tick();
    drive_ori(16'h2222);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", 128'(bus.out_valid), 128'd0);
    chk("rst2_ready", 128'(bus.in_ready), 128'd1);
    chk("rst2_data", {bus.out_data_1, bus.out_data_2}, 128'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("rst2_nothing", 128'(bus.out_valid), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
